// File: rtl/rv32i_prog_loader.sv
`default_nettype none
// ============================================================================
// rv32i_prog_loader : streams IMEM/DMEM images into the RV32i core, runs it,
// then dumps a data-memory window. Optional watchdog: RV32I_LOADER_TIMEOUT_EN.
// Revision 1.0
// ============================================================================
module rv32i_prog_loader #(
  parameter int unsigned IMEM_WORDS  = 1024,
  parameter int unsigned DMEM_WORDS  = 1024,
  parameter int unsigned DUMP_WORDS  = 16,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  input  logic        s_last,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic        m_last,
  output logic        CFG_wea_in,
  output logic [31:0] CFG_addr_in,
  output logic [31:0] CFG_dina_in,
  output logic        LDM_wea_in,
  output logic [31:0] LDM_addra_in,
  output logic [31:0] LDM_dina_in,
  input  logic [31:0] LDM_douta_out,
  output logic        start_in,
  input  logic        Met_jr_ra,
  output logic        busy,
  output logic        done,
  output logic        ovf_err,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD_I    = 3'd1,
    S_LOAD_D    = 3'd2,
    S_RUN       = 3'd3,
    S_DUMP_RD   = 3'd4,
    S_DUMP_WAIT = 3'd5,
    S_DUMP_OUT  = 3'd6,
    S_FIN       = 3'd7
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] icnt_q, icnt_d;
  logic [31:0] dcnt_q, dcnt_d;
  logic        cfg_wea_q, cfg_wea_d;
  logic [31:0] cfg_addr_q, cfg_addr_d;
  logic [31:0] cfg_din_q, cfg_din_d;
  logic        ldm_wea_q, ldm_wea_d;
  logic [31:0] ldm_addr_q, ldm_addr_d;
  logic [31:0] ldm_din_q, ldm_din_d;
  logic [31:0] m_data_q, m_data_d;
  logic        ovf_q, ovf_d;
  logic        wd_fire;
  logic        seq_start;

  assign seq_start = (state_q == S_IDLE) && go;

`ifdef RV32I_LOADER_TIMEOUT_EN
  logic [31:0] run_cnt_q, run_cnt_d;
  logic        tmo_q, tmo_d;

  // run_cnt_q holds the number of RUN cycles already completed.
  assign wd_fire = (state_q == S_RUN) && (run_cnt_q == TIMEOUT_CYC - 32'd1);

  always_comb begin
    run_cnt_d = (state_q == S_RUN) ? run_cnt_q + 32'd1 : 32'd0;
    tmo_d     = tmo_q;
    if (seq_start)
      tmo_d = 1'b0;
    else if (wd_fire && !Met_jr_ra)
      tmo_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt_q <= 32'd0;
      tmo_q     <= 1'b0;
    end else begin
      run_cnt_q <= run_cnt_d;
      tmo_q     <= tmo_d;
    end
  end

  assign timeout_err = tmo_q;
`else
  assign wd_fire     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    icnt_d     = icnt_q;
    dcnt_d     = dcnt_q;
    cfg_wea_d  = 1'b0;
    cfg_addr_d = cfg_addr_q;
    cfg_din_d  = cfg_din_q;
    ldm_wea_d  = 1'b0;
    ldm_addr_d = ldm_addr_q;
    ldm_din_d  = ldm_din_q;
    m_data_d   = m_data_q;
    ovf_d      = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          state_d = S_LOAD_I;
          icnt_d  = 32'd0;
          dcnt_d  = 32'd0;
          ovf_d   = 1'b0;
        end
      end
      S_LOAD_I: begin
        if (s_valid) begin
          // Words beyond capacity are still consumed so the host stream stays aligned.
          if (icnt_q < IMEM_WORDS) begin
            cfg_wea_d  = 1'b1;
            cfg_addr_d = {icnt_q[29:0], 2'b00};
            cfg_din_d  = s_data;
            icnt_d     = icnt_q + 32'd1;
          end else begin
            ovf_d = 1'b1;
          end
          if (s_last)
            state_d = S_LOAD_D;
        end
      end
      S_LOAD_D: begin
        if (s_valid) begin
          if (dcnt_q < DMEM_WORDS) begin
            ldm_wea_d  = 1'b1;
            ldm_addr_d = {dcnt_q[29:0], 2'b00};
            ldm_din_d  = s_data;
            dcnt_d     = dcnt_q + 32'd1;
          end else begin
            ovf_d = 1'b1;
          end
          if (s_last)
            state_d = S_RUN;
        end
      end
      S_RUN: begin
        // dcnt is reused as the dump index, so rewind it on the way out.
        if (Met_jr_ra || wd_fire) begin
          state_d    = S_DUMP_RD;
          dcnt_d     = 32'd0;
          ldm_addr_d = 32'd0;
        end
      end
      S_DUMP_RD: begin
        state_d = S_DUMP_WAIT;
      end
      S_DUMP_WAIT: begin
        m_data_d = LDM_douta_out;
        state_d  = S_DUMP_OUT;
      end
      S_DUMP_OUT: begin
        if (m_ready) begin
          dcnt_d = dcnt_q + 32'd1;
          if (dcnt_q == DUMP_WORDS - 32'd1) begin
            state_d = S_FIN;
          end else begin
            state_d    = S_DUMP_RD;
            ldm_addr_d = {dcnt_q[29:0] + 30'd1, 2'b00};
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      icnt_q     <= 32'd0;
      dcnt_q     <= 32'd0;
      cfg_wea_q  <= 1'b0;
      cfg_addr_q <= 32'd0;
      cfg_din_q  <= 32'd0;
      ldm_wea_q  <= 1'b0;
      ldm_addr_q <= 32'd0;
      ldm_din_q  <= 32'd0;
      m_data_q   <= 32'd0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      icnt_q     <= icnt_d;
      dcnt_q     <= dcnt_d;
      cfg_wea_q  <= cfg_wea_d;
      cfg_addr_q <= cfg_addr_d;
      cfg_din_q  <= cfg_din_d;
      ldm_wea_q  <= ldm_wea_d;
      ldm_addr_q <= ldm_addr_d;
      ldm_din_q  <= ldm_din_d;
      m_data_q   <= m_data_d;
      ovf_q      <= ovf_d;
    end
  end

  assign s_ready      = (state_q == S_LOAD_I) || (state_q == S_LOAD_D);
  assign m_valid      = (state_q == S_DUMP_OUT);
  assign m_last       = (state_q == S_DUMP_OUT) && (dcnt_q == DUMP_WORDS - 32'd1);
  assign m_data       = m_data_q;
  assign CFG_wea_in   = cfg_wea_q;
  assign CFG_addr_in  = cfg_addr_q;
  assign CFG_dina_in  = cfg_din_q;
  assign LDM_wea_in   = ldm_wea_q;
  assign LDM_addra_in = ldm_addr_q;
  assign LDM_dina_in  = ldm_din_q;
  assign start_in     = (state_q == S_RUN);
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_FIN);
  assign ovf_err      = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_rv32i_prog_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_rv32i_prog_loader : directed bench for the program loader.
// Revision 1.0
// ============================================================================
module tb_rv32i_prog_loader;
  localparam int unsigned C_IW   = 4;
  localparam int unsigned C_DW   = 8;
  localparam int unsigned C_NDMP = 4;
  localparam int unsigned C_TMO  = 50;

  logic        clk = 1'b0;
  logic        rst, go, s_valid, s_last, m_ready, Met_jr_ra;
  logic [31:0] s_data, LDM_douta_out;
  logic        s_ready, m_valid, m_last, CFG_wea_in, LDM_wea_in, start_in;
  logic        busy, done, ovf_err, timeout_err;
  logic [31:0] m_data, CFG_addr_in, CFG_dina_in, LDM_addra_in, LDM_dina_in;

  int n_total = 0;
  int n_bad   = 0;
  int base, lbase, n;

  always #5 clk = ~clk;

  rv32i_prog_loader #(
    .IMEM_WORDS(C_IW), .DMEM_WORDS(C_DW), .DUMP_WORDS(C_NDMP), .TIMEOUT_CYC(C_TMO)
  ) u_dut (
    .clk(clk), .rst(rst), .go(go),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .CFG_wea_in(CFG_wea_in), .CFG_addr_in(CFG_addr_in), .CFG_dina_in(CFG_dina_in),
    .LDM_wea_in(LDM_wea_in), .LDM_addra_in(LDM_addra_in), .LDM_dina_in(LDM_dina_in),
    .LDM_douta_out(LDM_douta_out),
    .start_in(start_in), .Met_jr_ra(Met_jr_ra),
    .busy(busy), .done(done), .ovf_err(ovf_err), .timeout_err(timeout_err)
  );

  // Write logs, one entry per cycle that a write enable is high.
  logic [31:0] cfg_a [0:63];
  logic [31:0] cfg_d [0:63];
  logic [31:0] ldm_a [0:63];
  logic [31:0] ldm_d [0:63];
  int cfg_n = 0;
  int ldm_n = 0;

  always @(negedge clk) begin
    if (CFG_wea_in && cfg_n < 64) begin
      cfg_a[cfg_n] = CFG_addr_in; cfg_d[cfg_n] = CFG_dina_in; cfg_n++;
    end
    if (LDM_wea_in && ldm_n < 64) begin
      ldm_a[ldm_n] = LDM_addra_in; ldm_d[ldm_n] = LDM_dina_in; ldm_n++;
    end
  end

  // Data memory with one-cycle read latency; core_wr mimics the program storing i at word i.
  logic [31:0] dmem [0:15];
  logic        core_wr;
  always @(posedge clk) begin
    if (core_wr)
      for (int i = 0; i < 16; i++) dmem[i] <= i;
    else if (LDM_wea_in)
      dmem[LDM_addra_in[5:2]] <= LDM_dina_in;
    LDM_douta_out <= dmem[LDM_addra_in[5:2]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic pulse_go;
    go = 1'b1; tick; go = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    s_valid = 1'b1; s_data = d; s_last = l;
    for (int k = 0; k < 20 && !s_ready; k++) tick;
    chk("s_ready", {31'd0, s_ready}, 32'd1);
    tick;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic dump(input logic [31:0] e0, e1, e2, e3, input int stall_word);
    logic [31:0] exp [4];
    exp = '{e0, e1, e2, e3};
    for (int w = 0; w < 4; w++) begin
      for (int k = 0; k < 20 && !m_valid; k++) tick;
      chk("m_valid", {31'd0, m_valid}, 32'd1);
      chk("m_data", m_data, exp[w]);
      chk("m_last", {31'd0, m_last}, (w == 3) ? 32'd1 : 32'd0);
      if (w == stall_word) begin
        for (int c = 0; c < 10; c++) begin
          tick;
          chk("stall_valid", {31'd0, m_valid}, 32'd1);
          chk("stall_data", m_data, exp[w]);
        end
      end
      m_ready = 1'b1; tick; m_ready = 1'b0;
      chk("m_valid_drop", {31'd0, m_valid}, 32'd0);
      chk("done", {31'd0, done}, (w == 3) ? 32'd1 : 32'd0);
    end
    tick;
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; go = 1'b0; s_valid = 1'b0; s_data = 32'd0; s_last = 1'b0;
    m_ready = 1'b0; Met_jr_ra = 1'b0; core_wr = 1'b0;
    tick; tick;
    chk("reset_outs", {22'd0, busy, s_ready, m_valid, m_last, start_in, done,
                       CFG_wea_in, LDM_wea_in, ovf_err, timeout_err}, 32'd0);
    chk("reset_mdata", m_data, 32'd0);
    rst = 1'b0; tick;

    // Normal load / run / dump with a 10-cycle stall on the second word.
    pulse_go;
    chk("busy_load", {31'd0, busy}, 32'd1);
    base = cfg_n; lbase = ldm_n;
    send(32'h00000013, 1'b0); send(32'h00000013, 1'b0);
    send(32'h00000013, 1'b0); send(32'h00008067, 1'b1);
    chk("no_start_in_load", {31'd0, start_in}, 32'd0);
    send(32'hA5A5A5A5, 1'b0); send(32'h5A5A5A5A, 1'b1);
    chk("start_rise", {31'd0, start_in}, 32'd1);
    tick;
    chk("cfg_count", cfg_n - base, 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("cfg_addr", cfg_a[base + i], 32'(4 * i));
      chk("cfg_data", cfg_d[base + i], (i == 3) ? 32'h00008067 : 32'h00000013);
    end
    chk("ldm_count", ldm_n - lbase, 32'd2);
    chk("ldm_addr0", ldm_a[lbase], 32'h0);
    chk("ldm_addr1", ldm_a[lbase + 1], 32'h4);
    chk("ldm_data0", ldm_d[lbase], 32'hA5A5A5A5);
    chk("ldm_data1", ldm_d[lbase + 1], 32'h5A5A5A5A);
    repeat (3) tick;
    chk("start_hold", {31'd0, start_in}, 32'd1);
    core_wr = 1'b1; tick; core_wr = 1'b0;
    Met_jr_ra = 1'b1; tick; Met_jr_ra = 1'b0;
    chk("start_drop", {31'd0, start_in}, 32'd0);
    dump(32'd0, 32'd1, 32'd2, 32'd3, 1);

    // IMEM overflow, 1-word DMEM image, Met_jr_ra already high on entering RUN.
    pulse_go;
    base = cfg_n; lbase = ldm_n;
    for (int i = 0; i < 5; i++) send(32'h100 + i, (i == 4));
    chk("ovf_set", {31'd0, ovf_err}, 32'd1);
    chk("ovf_in_load_d", {30'd0, s_ready, start_in}, 32'd2);
    Met_jr_ra = 1'b1;
    send(32'h00000011, 1'b1);
    chk("run_first", {31'd0, start_in}, 32'd1);
    tick;
    chk("run_one_cycle", {31'd0, start_in}, 32'd0);
    Met_jr_ra = 1'b0;
    chk("ovf_cfg_count", cfg_n - base, 32'd4);
    chk("ovf_cfg_addr3", cfg_a[base + 3], 32'hC);
    chk("ovf_cfg_data3", cfg_d[base + 3], 32'h103);
    chk("one_word_ldm", ldm_n - lbase, 32'd1);
    chk("one_word_data", ldm_d[lbase], 32'h11);
    dump(32'h11, 32'd1, 32'd2, 32'd3, -1);
    chk("ovf_sticky", {31'd0, ovf_err}, 32'd1);

    // Run with no completion flag.
    pulse_go;
    chk("ovf_cleared", {31'd0, ovf_err}, 32'd0);
    send(32'h00000013, 1'b1);
    send(32'hDEAD0001, 1'b1);
    chk("start_run3", {31'd0, start_in}, 32'd1);
`ifdef RV32I_LOADER_TIMEOUT_EN
    n = 1;
    for (int k = 0; k < 200; k++) begin
      tick;
      if (!start_in) break;
      n++;
    end
    chk("run_cycles", n, C_TMO);
    chk("timeout_set", {31'd0, timeout_err}, 32'd1);
    dump(32'hDEAD0001, 32'd1, 32'd2, 32'd3, -1);
    chk("timeout_sticky", {31'd0, timeout_err}, 32'd1);
`else
    repeat (60) tick;
    chk("no_watchdog_run", {31'd0, start_in}, 32'd1);
    chk("no_watchdog_err", {31'd0, timeout_err}, 32'd0);
    Met_jr_ra = 1'b1; tick; Met_jr_ra = 1'b0;
    dump(32'hDEAD0001, 32'd1, 32'd2, 32'd3, -1);
`endif

    // Reset during the second IMEM word, then restart.
    pulse_go;
    base = cfg_n;
    send(32'hAAAA0000, 1'b0);
    s_valid = 1'b1; s_data = 32'hBBBB0001; rst = 1'b1;
    tick;
    rst = 1'b0; s_valid = 1'b0;
    chk("mid_rst_outs", {22'd0, busy, s_ready, m_valid, m_last, start_in, done,
                         CFG_wea_in, LDM_wea_in, ovf_err, timeout_err}, 32'd0);
    tick;
    chk("mid_rst_writes", cfg_n - base, 32'd1);
    pulse_go;
    send(32'hC0C0C0C0, 1'b0); send(32'hC1C1C1C1, 1'b1);
    tick;
    chk("restart_count", cfg_n - base, 32'd3);
    chk("restart_addr0", cfg_a[base + 1], 32'h0);
    chk("restart_addr1", cfg_a[base + 2], 32'h4);
    chk("restart_data0", cfg_d[base + 1], 32'hC0C0C0C0);
    rst = 1'b1; tick; rst = 1'b0;
    chk("final_idle", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
